player_motion: RTL and testbench

Parametrised player motion controller for the VGA game: tracks the player sprite's x/y screen coordinates. It adds horizontal movement with screen-edge clamping, gravity-based jump arcs and a configurable multi-jump count. It advances once per game tick and sits between the button inputs and the sprite renderer and collision logic.

---
 rtl/player_motion_if.sv | 24 ++
 rtl/player_motion.sv | 137 +++++++++++++
 tb/tb_player_motion.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/player_motion_if.sv
// Button/tick inputs and sprite position outputs of the player motion controller.
interface player_motion_if #(
  parameter int unsigned W = 16
);
  logic         tick;
  logic         enable;
  logic         btn_jump;
  logic         btn_left;
  logic         btn_right;
  logic [W-1:0] x_player;
  logic [W-1:0] y_player;
  logic         airborne;
  logic         landed;

  modport master (
    output tick, enable, btn_jump, btn_left, btn_right,
    input  x_player, y_player, airborne, landed
  );

  modport slave (
    input  tick, enable, btn_jump, btn_left, btn_right,
    output x_player, y_player, airborne, landed
  );
endinterface

// File: rtl/player_motion.sv
// Player sprite motion: clamped horizontal moves, gravity jump arcs and multi-jump,
// advanced once per game tick.
module player_motion #(
  parameter int unsigned W          = 16,
  parameter int unsigned X_INIT     = 200,
  parameter int unsigned X_MIN      = 0,
  parameter int unsigned X_MAX      = 600,
  parameter int unsigned X_STEP     = 1,
  parameter int unsigned Y_GROUND   = 400,
  parameter int unsigned Y_MIN      = 0,
  parameter int unsigned V_JUMP     = 12,
  parameter int unsigned V_FALL_MAX = 12,
  parameter int unsigned GRAV_TICKS = 8,
  parameter int unsigned MAX_JUMPS  = 2
) (
  input logic            clk,
  input logic            reset,
  player_motion_if.slave bus
);
  localparam int unsigned JW = $clog2(MAX_JUMPS + 1);
  localparam int unsigned GW = (GRAV_TICKS > 1) ? $clog2(GRAV_TICKS) : 1;
  localparam int VFallNegI = -int'(V_FALL_MAX);
  localparam logic signed [W-1:0] VFallNeg = W'(VFallNegI);
  localparam logic signed [W-1:0] VJump    = W'(V_JUMP);
  localparam logic signed [W-1:0] VOne     = W'(1);
  localparam logic signed [W:0]   YGroundS = (W+1)'(Y_GROUND);
  localparam logic signed [W:0]   YMinS    = (W+1)'(Y_MIN);

  typedef enum logic [1:0] {StIdle, StGround, StAir} state_e;

  state_e              state_q;
  logic [W-1:0]        x_q, y_q;
  logic signed [W-1:0] vy_q;
  logic [JW-1:0]       jumps_q;
  logic [GW-1:0]       grav_cnt_q;
  logic                pending_q, btn_q, airborne_q, landed_q;

  logic                rise, req;
  logic [W:0]          x_sum;
  logic [W-1:0]        x_mv;
  logic signed [W:0]   y_nx;
  logic                hit_ceiling, grav_wrap;
  logic signed [W-1:0] vy_base, vy_grav;

  assign rise = bus.btn_jump & ~btn_q;
  assign req  = pending_q | rise;

  assign x_sum = {1'b0, x_q} + (W+1)'(X_STEP);

  always_comb begin
    x_mv = x_q;
    if (bus.btn_right && !bus.btn_left) begin
      x_mv = (x_sum > (W+1)'(X_MAX)) ? W'(X_MAX) : x_sum[W-1:0];
    end else if (bus.btn_left && !bus.btn_right) begin
      x_mv = ({1'b0, x_q} < (W+1)'(X_MIN + X_STEP)) ? W'(X_MIN) : x_q - W'(X_STEP);
    end
  end

  // Positive vy is upward, so the screen y shrinks by vy.
  assign y_nx        = $signed({1'b0, y_q}) - $signed({vy_q[W-1], vy_q});
  assign hit_ceiling = y_nx < YMinS;
  assign vy_base     = hit_ceiling ? '0 : vy_q;
  assign grav_wrap   = grav_cnt_q == GW'(GRAV_TICKS - 1);

  always_comb begin
    vy_grav = vy_base;
    if (grav_wrap) begin
      vy_grav = (vy_base <= VFallNeg) ? VFallNeg : vy_base - VOne;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      x_q        <= W'(X_INIT);
      y_q        <= W'(Y_GROUND);
      vy_q       <= '0;
      jumps_q    <= '0;
      grav_cnt_q <= '0;
      pending_q  <= 1'b0;
      btn_q      <= 1'b0;
      airborne_q <= 1'b0;
      landed_q   <= 1'b0;
    end else begin
      btn_q    <= bus.btn_jump;
      landed_q <= 1'b0;
      if (!bus.enable) begin
        pending_q <= 1'b0;
      end else if (bus.tick) begin
        // Every processed tick consumes the request, accepted or not.
        pending_q <= 1'b0;
        if (state_q != StIdle) x_q <= x_mv;
        unique case (state_q)
          StIdle: begin
            if (req) state_q <= StGround;
          end
          StGround: begin
            if (req) begin
              vy_q       <= VJump;
              jumps_q    <= JW'(1);
              grav_cnt_q <= '0;
              state_q    <= StAir;
              airborne_q <= 1'b1;
            end
          end
          StAir: begin
            if (req && (jumps_q < JW'(MAX_JUMPS))) begin
              vy_q       <= VJump;
              jumps_q    <= jumps_q + JW'(1);
              grav_cnt_q <= '0;
            end else if (y_nx >= YGroundS) begin
              y_q        <= W'(Y_GROUND);
              vy_q       <= '0;
              jumps_q    <= '0;
              grav_cnt_q <= '0;
              state_q    <= StGround;
              airborne_q <= 1'b0;
              landed_q   <= 1'b1;
            end else begin
              y_q        <= hit_ceiling ? W'(Y_MIN) : y_nx[W-1:0];
              vy_q       <= vy_grav;
              grav_cnt_q <= grav_wrap ? '0 : grav_cnt_q + GW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end else if (rise) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign bus.x_player = x_q;
  assign bus.y_player = y_q;
  assign bus.airborne = airborne_q;
  assign bus.landed   = landed_q;
endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: directed arc/jump/clamp/ceiling/reset/enable scenarios on two
// configurations plus a randomized run against a behavioural model.
module tb_player_motion;
  localparam int XMax = 600, XMin = 0, YGround = 400, VFall = 12, MaxJumps = 2;
  localparam int MIdle = 0, MGround = 1, MAir = 2;

  typedef struct {
    int x_init; int x_step; int y_min; int v_jump; int grav;
  } cfg_t;
  typedef struct {
    int mode; int x; int y; int vy; int jumps; int gcnt; bit pend; bit btnq; bit landed;
  } ms_t;

  logic clk = 1'b0, reset = 1'b0;
  logic tick = 1'b0, enable = 1'b1, bj = 1'b0, bl = 1'b0, br = 1'b0;
  int   pass_cnt = 0, chk_cnt = 0;

  cfg_t ca = '{x_init: 200, x_step: 1, y_min: 0,   v_jump: 4, grav: 1};
  cfg_t cb = '{x_init: 201, x_step: 2, y_min: 395, v_jump: 8, grav: 8};
  ms_t  ma, mb;

  always #5 clk = ~clk;

  player_motion_if #(.W(16)) if_a ();
  player_motion_if #(.W(16)) if_b ();

  assign if_a.tick = tick;  assign if_a.enable = enable;  assign if_a.btn_jump = bj;
  assign if_a.btn_left = bl;  assign if_a.btn_right = br;
  assign if_b.tick = tick;  assign if_b.enable = enable;  assign if_b.btn_jump = bj;
  assign if_b.btn_left = bl;  assign if_b.btn_right = br;

  player_motion #(.X_INIT(200), .X_STEP(1), .Y_MIN(0), .V_JUMP(4), .GRAV_TICKS(1)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a)
  );
  player_motion #(.X_INIT(201), .X_STEP(2), .Y_MIN(395), .V_JUMP(8), .GRAV_TICKS(8)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b)
  );

  function automatic ms_t mreset(cfg_t c);
    ms_t n = '{mode: MIdle, x: c.x_init, y: YGround, vy: 0, jumps: 0, gcnt: 0,
               pend: 1'b0, btnq: 1'b0, landed: 1'b0};
    return n;
  endfunction

  function automatic ms_t mstep(ms_t s, cfg_t c, bit tk, bit en, bit jb, bit lb, bit rb);
    ms_t n = s;
    bit  rise = jb && !s.btnq;
    bit  req;
    int  ny;
    n.btnq = jb;
    n.landed = 1'b0;
    if (!en) begin
      n.pend = 1'b0;
      return n;
    end
    if (!tk) begin
      if (rise) n.pend = 1'b1;
      return n;
    end
    req = s.pend || rise;
    n.pend = 1'b0;
    if (s.mode != MIdle && lb != rb) begin
      if (rb) n.x = (s.x + c.x_step > XMax) ? XMax : s.x + c.x_step;
      else    n.x = (s.x - c.x_step < XMin) ? XMin : s.x - c.x_step;
    end
    if (s.mode == MIdle) begin
      if (req) n.mode = MGround;
    end else if (s.mode == MGround) begin
      if (req) begin n.mode = MAir; n.vy = c.v_jump; n.jumps = 1; n.gcnt = 0; end
    end else if (req && s.jumps < MaxJumps) begin
      n.vy = c.v_jump; n.jumps = s.jumps + 1; n.gcnt = 0;
    end else begin
      ny = s.y - s.vy;
      if (ny >= YGround) begin
        n.y = YGround; n.vy = 0; n.jumps = 0; n.mode = MGround; n.landed = 1'b1;
      end else begin
        if (ny < c.y_min) begin n.y = c.y_min; n.vy = 0; end
        else n.y = ny;
        n.gcnt = (s.gcnt + 1) % c.grav;
        if (n.gcnt == 0) n.vy = (n.vy - 1 < -VFall) ? -VFall : n.vy - 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ma <= mreset(ca);
      mb <= mreset(cb);
    end else begin
      ma <= mstep(ma, ca, tick, enable, bj, bl, br);
      mb <= mstep(mb, cb, tick, enable, bj, bl, br);
    end
  end

  task automatic tick_once();
    @(negedge clk); tick = 1'b1;
    @(posedge clk); #1; tick = 1'b0;
  endtask

  task automatic press();
    @(negedge clk); bj = 1'b1;
    @(negedge clk); bj = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; bj = 1'b0; bl = 1'b0; br = 1'b0; enable = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic leave_idle();
    press();
    tick_once();
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b1; #1;
    chk_cnt++; if (if_a.x_player !== 16'd200) $display("FAIL rst_xa: got %0d expected 200", if_a.x_player); else pass_cnt++;
    chk_cnt++; if (if_a.y_player !== 16'd400) $display("FAIL rst_ya: got %0d expected 400", if_a.y_player); else pass_cnt++;
    chk_cnt++; if (if_b.x_player !== 16'd201) $display("FAIL rst_xb: got %0d expected 201", if_b.x_player); else pass_cnt++;
    chk_cnt++; if (if_a.airborne !== 1'b0 || if_a.landed !== 1'b0)
      $display("FAIL rst_flags: got air=%b land=%b expected 0 0", if_a.airborne, if_a.landed); else pass_cnt++;
    @(negedge clk); reset = 1'b0; br = 1'b1;
    tick_once();
    chk_cnt++; if (if_a.x_player !== 16'd200) $display("FAIL idle_x: got %0d expected 200", if_a.x_player); else pass_cnt++;
    br = 1'b0;
  endtask

  task automatic test_arc();
    int exp_y[9] = '{396, 393, 391, 390, 390, 391, 393, 396, 400};
    do_reset();
    leave_idle();
    chk_cnt++; if (if_a.airborne !== 1'b0 || if_a.y_player !== 16'd400)
      $display("FAIL arc_idle_exit: got air=%b y=%0d expected 0 400", if_a.airborne, if_a.y_player); else pass_cnt++;
    press();
    tick_once();
    chk_cnt++; if (if_a.airborne !== 1'b1 || if_a.y_player !== 16'd400)
      $display("FAIL arc_takeoff: got air=%b y=%0d expected 1 400", if_a.airborne, if_a.y_player); else pass_cnt++;
    for (int i = 0; i < 9; i++) begin
      tick_once();
      chk_cnt++; if (if_a.y_player !== 16'(exp_y[i]))
        $display("FAIL arc_y[%0d]: got %0d expected %0d", i, if_a.y_player, exp_y[i]); else pass_cnt++;
      chk_cnt++; if (if_a.landed !== (i == 8) || if_a.airborne !== (i != 8))
        $display("FAIL arc_flags[%0d]: got land=%b air=%b expected %b %b", i, if_a.landed,
                 if_a.airborne, (i == 8), (i != 8)); else pass_cnt++;
    end
    @(posedge clk); #1;
    chk_cnt++; if (if_a.landed !== 1'b0) $display("FAIL arc_land_pulse: got %b expected 0", if_a.landed); else pass_cnt++;
  endtask

  task automatic test_double_jump();
    int exp_y[10] = '{386, 384, 383, 383, 384, 386, 389, 393, 398, 400};
    do_reset();
    leave_idle();
    press(); tick_once(); tick_once(); tick_once();
    chk_cnt++; if (if_a.y_player !== 16'd393) $display("FAIL dj_pre: got %0d expected 393", if_a.y_player); else pass_cnt++;
    press(); tick_once();
    chk_cnt++; if (if_a.y_player !== 16'd393) $display("FAIL dj_reload: got %0d expected 393", if_a.y_player); else pass_cnt++;
    tick_once();
    chk_cnt++; if (if_a.y_player !== 16'd389) $display("FAIL dj_next: got %0d expected 389", if_a.y_player); else pass_cnt++;
    press();
    for (int i = 0; i < 10; i++) begin
      tick_once();
      chk_cnt++; if (if_a.y_player !== 16'(exp_y[i]))
        $display("FAIL dj_third_y[%0d]: got %0d expected %0d", i, if_a.y_player, exp_y[i]); else pass_cnt++;
    end
    chk_cnt++; if (if_a.landed !== 1'b1) $display("FAIL dj_land: got %b expected 1", if_a.landed); else pass_cnt++;
    tick_once();
    chk_cnt++; if (if_a.airborne !== 1'b0 || if_a.y_player !== 16'd400)
      $display("FAIL dj_pending_clear: got air=%b y=%0d expected 0 400", if_a.airborne, if_a.y_player); else pass_cnt++;
  endtask

  task automatic test_clamp();
    do_reset();
    leave_idle();
    br = 1'b1;
    repeat (199) tick_once();
    chk_cnt++; if (if_b.x_player !== 16'd599) $display("FAIL clamp_pre: got %0d expected 599", if_b.x_player); else pass_cnt++;
    tick_once();
    chk_cnt++; if (if_b.x_player !== 16'd600) $display("FAIL clamp_max: got %0d expected 600", if_b.x_player); else pass_cnt++;
    tick_once();
    chk_cnt++; if (if_b.x_player !== 16'd600) $display("FAIL clamp_hold: got %0d expected 600", if_b.x_player); else pass_cnt++;
    bl = 1'b1;
    tick_once();
    chk_cnt++; if (if_b.x_player !== 16'd600) $display("FAIL clamp_both: got %0d expected 600", if_b.x_player); else pass_cnt++;
    br = 1'b0;
    tick_once();
    chk_cnt++; if (if_b.x_player !== 16'd598) $display("FAIL clamp_left: got %0d expected 598", if_b.x_player); else pass_cnt++;
    bl = 1'b0;
  endtask

  task automatic test_ceiling();
    do_reset();
    leave_idle();
    press(); tick_once();
    for (int i = 0; i < 13; i++) begin
      tick_once();
      chk_cnt++; if (if_b.y_player !== 16'((i < 8) ? 395 : 388 + i))
        $display("FAIL ceil_y[%0d]: got %0d expected %0d", i, if_b.y_player, (i < 8) ? 395 : 388 + i); else pass_cnt++;
    end
    chk_cnt++; if (if_b.landed !== 1'b1 || if_b.airborne !== 1'b0)
      $display("FAIL ceil_land: got land=%b air=%b expected 1 0", if_b.landed, if_b.airborne); else pass_cnt++;
  endtask

  task automatic test_reset_midair();
    do_reset();
    leave_idle();
    press(); tick_once(); tick_once(); tick_once(); tick_once();
    chk_cnt++; if (if_a.y_player !== 16'd391) $display("FAIL rm_pre: got %0d expected 391", if_a.y_player); else pass_cnt++;
    #2; reset = 1'b1; #1;
    chk_cnt++; if (if_a.x_player !== 16'd200 || if_a.y_player !== 16'd400)
      $display("FAIL rm_pos: got x=%0d y=%0d expected 200 400", if_a.x_player, if_a.y_player); else pass_cnt++;
    chk_cnt++; if (if_a.airborne !== 1'b0 || if_a.landed !== 1'b0)
      $display("FAIL rm_flags: got air=%b land=%b expected 0 0", if_a.airborne, if_a.landed); else pass_cnt++;
    @(negedge clk); reset = 1'b0;
    tick_once();
    chk_cnt++; if (if_a.airborne !== 1'b0) $display("FAIL rm_idle: got %b expected 0", if_a.airborne); else pass_cnt++;
  endtask

  task automatic test_edge_enable();
    int hold_y[5] = '{400, 396, 393, 391, 390};
    int res_y[5]  = '{390, 391, 393, 396, 400};
    do_reset();
    leave_idle();
    @(negedge clk); bj = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick_once();
      chk_cnt++; if (if_a.y_player !== 16'(hold_y[i]) || if_a.airborne !== 1'b1)
        $display("FAIL hold_y[%0d]: got y=%0d air=%b expected %0d 1", i, if_a.y_player,
                 if_a.airborne, hold_y[i]); else pass_cnt++;
    end
    bj = 1'b0;
    enable = 1'b0;
    press();
    for (int i = 0; i < 3; i++) begin
      tick_once();
      chk_cnt++; if (if_a.y_player !== 16'd390 || if_a.airborne !== 1'b1)
        $display("FAIL frozen[%0d]: got y=%0d air=%b expected 390 1", i, if_a.y_player, if_a.airborne); else pass_cnt++;
    end
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick_once();
      chk_cnt++; if (if_a.y_player !== 16'(res_y[i]))
        $display("FAIL resume_y[%0d]: got %0d expected %0d", i, if_a.y_player, res_y[i]); else pass_cnt++;
    end
    chk_cnt++; if (if_a.landed !== 1'b1) $display("FAIL resume_land: got %b expected 1", if_a.landed); else pass_cnt++;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      tick   = ($urandom_range(0, 2) == 0);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) bj = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) bl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) br = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk_cnt++; if (if_a.x_player !== 16'(ma.x) || if_a.y_player !== 16'(ma.y))
        $display("FAIL rnd_a_pos @%0d: got %0d,%0d expected %0d,%0d", n, if_a.x_player,
                 if_a.y_player, ma.x, ma.y); else pass_cnt++;
      chk_cnt++; if (if_a.airborne !== (ma.mode == MAir) || if_a.landed !== ma.landed)
        $display("FAIL rnd_a_flags @%0d: got %b%b expected %b%b", n, if_a.airborne, if_a.landed,
                 (ma.mode == MAir), ma.landed); else pass_cnt++;
      chk_cnt++; if (if_b.x_player !== 16'(mb.x) || if_b.y_player !== 16'(mb.y))
        $display("FAIL rnd_b_pos @%0d: got %0d,%0d expected %0d,%0d", n, if_b.x_player,
                 if_b.y_player, mb.x, mb.y); else pass_cnt++;
      chk_cnt++; if (if_b.airborne !== (mb.mode == MAir) || if_b.landed !== mb.landed)
        $display("FAIL rnd_b_flags @%0d: got %b%b expected %b%b", n, if_b.airborne, if_b.landed,
                 (mb.mode == MAir), mb.landed); else pass_cnt++;
    end
    tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arc();
    test_double_jump();
    test_clamp();
    test_ceiling();
    test_reset_midair();
    test_edge_enable();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
